sigmoid_backprop: RTL and testbench
===================================

Name: sigmoid_backprop

Overview:
- Backward-pass partner of the forward sigmoid unit in the neural-network datapath.
- Takes a stored forward activation s = sigmoid(x) and an upstream gradient g.
- Returns the local gradient delta = g * s * (1 - s).
- Multi-cycle and iterative: one shared add_sub and one shared multiplier, sequenced by an FSM, with valid/ready handshakes on both sides. It sits between the layer's activation store and the weight-update logic.

Parameters:
- exp_width, 8, exponent field width of the FP format.
- mant_width, 24, mantissa width including hidden bit. The word width is W = exp_width + mant_width, which is 32 for the defaults.

Ports:
- clk  input  1  clock
- rst_l  input  1  asynchronous active-low reset
- round_mode  input  3  rounding mode passed to the add_sub and multiplier instances
- flush  input  1  synchronous abort; discards the operation in flight
- in_valid  input  1  in_s/in_grad valid
- in_ready  output  1  block can accept an operand pair
- in_s  input  W  forward sigmoid activation s (FP)
- in_grad  input  W  upstream gradient g (FP)
- out_valid  output  1  out_delta valid
- out_ready  input  1  consumer accepts out_delta
- out_delta  output  W  g*s*(1-s) (FP)

Behaviour:
- Reset and clock: reset rst_l, asynchronous, active-low; clock clk.
  - Reset forces state IDLE and clears all operand/intermediate registers to 0.
  - Output reset values: out_valid=0, out_delta=0, in_ready=1.
- FSM states: IDLE, SUB, MUL_D, MUL_G, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register s_reg<=in_s and g_reg<=in_grad, then go to SUB.
  - SUB: add_sub computes 1.0 (32'h3f800000) minus s_reg (operation=1). Register om_reg, go to MUL_D.
  - MUL_D: multiplier computes s_reg*om_reg. Register d_reg, go to MUL_G.
  - MUL_G: multiplier computes d_reg*g_reg. Register res_reg, go to DONE.
  - DONE: out_valid=1 and out_delta=res_reg. On out_ready, go to IDLE.
- Operand muxing: the multiplier operands are muxed by state. MUL_D selects (s_reg, om_reg); MUL_G selects (d_reg, g_reg).
- Latency and throughput:
  - out_valid rises 3 clock edges after the accepting edge.
  - Minimum spacing between accepts is 5 cycles, because in_ready is high only in IDLE. Accept in the same cycle as the DONE handshake is not supported.
- Backpressure: while DONE and out_ready=0, out_valid and out_delta hold stable and in_ready stays 0.
- out_delta is registered; it never glitches with state changes.
- flush:
  - In any state, flush=1 at a clock edge forces IDLE and out_valid=0. The result is dropped; data registers keep their values.
  - flush has priority over acceptance. If flush=1 and in_valid=1 in IDLE, nothing is accepted.
- Asynchronous reset mid-operation: immediate return to reset values. No partial result is ever presented.
- Arithmetic rules:
  - No range check on s. Values outside [0,1] are computed as given.
  - NaN/Inf/zero handling follows the add_sub and multiplier units.
  - s=1.0 or s=0.0 yields a signed zero. The sign follows the multiplier's IEEE sign rule.
- in_s and in_grad are sampled only on the accepting edge. Changes at other times are ignored.

Optional Feature:
- SIGMOID_BACKPROP_EXC_EN, when defined, adds output port exc_flags (5 bits).
  - exc_flags is the OR of the 5-bit exception outputs of add_sub in SUB and of the multiplier in MUL_D and MUL_G. It accumulates over one operation.
  - It is cleared on accept, valid alongside out_valid, and reset to 0. flush clears it.
- When SIGMOID_BACKPROP_EXC_EN is undefined, there is no exc_flags port and the unit exception outputs are left unconnected.

Test Plan:
- s=32'h3f000000 (0.5), g=32'h3f800000 (1.0), out_ready=1, round_mode=0 -> out_valid after 3 edges, out_delta=32'h3e800000 (0.25); in_ready high again the cycle after the handshake.
- s=32'h3f400000 (0.75), g=32'h40000000 (2.0) -> out_delta=32'h3ec00000 (0.375). Also s=0.5, g=32'hc0800000 (-4.0) -> 32'hbf800000 (-1.0).
- s=32'h3f800000 (1.0), g=32'h40a00000 (5.0) -> out_delta=32'h00000000; with EXC_EN, exc_flags=0.
- Backpressure: complete an op with out_ready=0 for 10 cycles -> out_valid=1 and out_delta constant throughout, in_ready=0, in_valid pulses ignored; out_ready=1 -> back to IDLE.
- flush asserted in MUL_D -> next cycle IDLE, out_valid never rises, in_ready=1; a following op gives the correct result.
- rst_l low in MUL_G -> out_valid=0, out_delta=0, in_ready=1 immediately; after release, s=0.5, g=1.0 -> 32'h3e800000.

Source files
------------

// File: rtl/sigmoid_backprop.sv
// sigmoid_backprop: iterative sigmoid backward pass, delta = g * s * (1 - s).
// Defining SIGMOID_BACKPROP_EXC_EN adds the accumulated exc_flags output.
module sigmoid_backprop #(
    parameter int unsigned exp_width  = 8,
    parameter int unsigned mant_width = 24
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic [2:0]                      round_mode,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [exp_width+mant_width-1:0] in_s,
    input  logic [exp_width+mant_width-1:0] in_grad,
    output logic                            out_valid,
    input  logic                            out_ready,
`ifdef SIGMOID_BACKPROP_EXC_EN
    output logic [4:0]                      exc_flags,
`endif
    output logic [exp_width+mant_width-1:0] out_delta
);
    localparam int unsigned E    = exp_width;
    localparam int unsigned M    = mant_width;
    localparam int unsigned F    = M - 1;
    localparam int unsigned W    = E + M;
    localparam int unsigned EW   = E + 2;
    localparam int unsigned BIAS = (1 << (E - 1)) - 1;
    localparam int unsigned EMAX = (1 << E) - 1;
    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
    localparam logic [W-1:0] ONE  = {1'b0, E'(BIAS), F'(0)};
    localparam logic [W-1:0] QNAN = {1'b0, E'(EMAX), 1'b1, (F-1)'(0)};

    typedef enum logic [2:0] {IDLE, SUB, MUL_D, MUL_G, DONE} state_t;

    state_t       state;
    logic [W-1:0] s_reg, g_reg, om_reg, d_reg, mul_a, mul_b;
    logic [W+4:0] add_res, mul_res;

    function automatic logic is_inf(input logic [W-1:0] x);
        return (x[W-2:F] == E'(EMAX)) && (x[F-1:0] == '0);
    endfunction

    function automatic logic is_nan(input logic [W-1:0] x);
        return (x[W-2:F] == E'(EMAX)) && (x[F-1:0] != '0);
    endfunction

    function automatic logic is_snan(input logic [W-1:0] x);
        return is_nan(x) && !x[F-1];
    endfunction

    // Subnormal inputs are treated as zero.
    function automatic logic is_zero(input logic [W-1:0] x);
        return x[W-2:F] == '0;
    endfunction

    function automatic logic rnd_inc(input logic sign, input logic lsb, input logic g,
                                     input logic st, input logic [2:0] rm);
        case (rm)
            3'd1:    return 1'b0;
            3'd2:    return sign & (g | st);
            3'd3:    return ~sign & (g | st);
            3'd4:    return g;
            default: return g & (st | lsb);
        endcase
    endfunction

    // Round, then pack; returns {nv, dz, of, uf, nx, word}.
    function automatic logic [W+4:0] fp_pack(input logic sign, input logic signed [EW-1:0] exp_in,
                                             input logic [F-1:0] frac, input logic g,
                                             input logic st, input logic [2:0] rm);
        logic signed [EW-1:0] ez;
        logic [F:0]           rsum;
        logic                 to_inf;
        ez     = exp_in;
        rsum   = {1'b0, frac} + (F+1)'(rnd_inc(sign, frac[0], g, st, rm));
        if (rsum[F]) ez = ez + EW'(1);
        to_inf = (rm == 3'd0) || (rm == 3'd4) || ((rm == 3'd3) && !sign) || ((rm == 3'd2) && sign);
        if (ez >= EMAX_S)
            return to_inf ? {5'b00101, sign, E'(EMAX), F'(0)}
                          : {5'b00101, sign, E'(EMAX - 1), {F{1'b1}}};
        if (ez[EW-1] || (ez == '0)) return {5'b00011, sign, (W-1)'(0)};
        return {4'b0000, g | st, sign, ez[E-1:0], rsum[F-1:0]};
    endfunction

    function automatic logic [W+4:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] rm);
        logic                 sz, g, st;
        logic [2*M-1:0]       prod;
        logic [F-1:0]         frac;
        logic signed [EW-1:0] ez;
        sz = a[W-1] ^ b[W-1];
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b)))
            return {is_snan(a) || is_snan(b) || !(is_nan(a) || is_nan(b)), 4'b0000, QNAN};
        if (is_inf(a) || is_inf(b)) return {5'b00000, sz, E'(EMAX), F'(0)};
        if (is_zero(a) || is_zero(b)) return {5'b00000, sz, (W-1)'(0)};
        prod = (2*M)'({1'b1, a[F-1:0]}) * (2*M)'({1'b1, b[F-1:0]});
        ez   = EW'(a[W-2:F]) + EW'(b[W-2:F]) - EW'(BIAS);
        if (prod[2*M-1]) begin
            frac = prod[2*M-2 -: F];
            g    = prod[M-1];
            st   = |prod[M-2:0];
            ez   = ez + EW'(1);
        end else begin
            frac = prod[2*M-3 -: F];
            g    = prod[M-2];
            st   = |prod[M-3:0];
        end
        return fp_pack(sz, ez, frac, g, st, rm);
    endfunction

    // op=1 subtracts b from a.
    function automatic logic [W+4:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b_in,
                                            input logic op, input logic [2:0] rm);
        logic [W-1:0]         b, x, y;
        logic [E-1:0]         d;
        logic [M+2:0]         mx, my, ys;
        logic [M+3:0]         sum;
        logic signed [EW-1:0] ez;
        b = {b_in[W-1] ^ op, b_in[W-2:0]};
        if (is_nan(a) || is_nan(b)) return {is_snan(a) || is_snan(b), 4'b0000, QNAN};
        if (is_inf(a) && is_inf(b) && (a[W-1] != b[W-1])) return {5'b10000, QNAN};
        if (is_inf(a)) return {5'b00000, a};
        if (is_inf(b)) return {5'b00000, b};
        if (is_zero(a) && is_zero(b))
            return {5'b00000, (a[W-1] & b[W-1]) | ((a[W-1] ^ b[W-1]) & (rm == 3'd2)), (W-1)'(0)};
        if (is_zero(a)) return {5'b00000, b};
        if (is_zero(b)) return {5'b00000, a};
        if (a[W-2:0] >= b[W-2:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        mx = {1'b1, x[F-1:0], 3'b000};
        my = {1'b1, y[F-1:0], 3'b000};
        d  = x[W-2:F] - y[W-2:F];
        if (32'(d) >= M + 3) ys = (M+3)'(1);
        else ys = (my >> d) | (M+3)'((my << (M + 3 - 32'(d))) != '0);
        ez = EW'(x[W-2:F]);
        if (x[W-1] == y[W-1]) begin
            sum = {1'b0, mx} + {1'b0, ys};
            if (sum[M+3]) begin
                sum = {1'b0, sum[M+3:2], sum[1] | sum[0]};
                ez  = ez + EW'(1);
            end
        end else begin
            sum = {1'b0, mx} - {1'b0, ys};
            if (sum == '0) return {5'b00000, rm == 3'd2, (W-1)'(0)};
            for (int i = 0; i < int'(M + 2); i++) begin
                if (!sum[M+2]) begin
                    sum = sum << 1;
                    ez  = ez - EW'(1);
                end
            end
        end
        return fp_pack(x[W-1], ez, sum[M+1:3], sum[2], |sum[1:0], rm);
    endfunction

    // Shared multiplier operands are steered by the current step.
    always_comb begin
        mul_a = s_reg;
        mul_b = om_reg;
        if (state == MUL_G) begin
            mul_a = d_reg;
            mul_b = g_reg;
        end
        add_res = fp_add(ONE, s_reg, 1'b1, round_mode);
        mul_res = fp_mul(mul_a, mul_b, round_mode);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            s_reg     <= '0;
            g_reg     <= '0;
            om_reg    <= '0;
            d_reg     <= '0;
            out_delta <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    s_reg    <= in_s;
                    g_reg    <= in_grad;
                    in_ready <= 1'b0;
                    state    <= SUB;
                end
                SUB: begin
                    om_reg <= add_res[W-1:0];
                    state  <= MUL_D;
                end
                MUL_D: begin
                    d_reg <= mul_res[W-1:0];
                    state <= MUL_G;
                end
                MUL_G: begin
                    out_delta <= mul_res[W-1:0];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SIGMOID_BACKPROP_EXC_EN
    // Flags accumulate across the three arithmetic steps of one operation.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            exc_flags <= '0;
        end else if (flush) begin
            exc_flags <= '0;
        end else begin
            case (state)
                IDLE:         if (in_valid && in_ready) exc_flags <= '0;
                SUB:          exc_flags <= exc_flags | add_res[W+4:W];
                MUL_D, MUL_G: exc_flags <= exc_flags | mul_res[W+4:W];
                default:      ;
            endcase
        end
    end
`else
    logic unused_exc;
    assign unused_exc = ^{add_res[W+4:W], mul_res[W+4:W]};
`endif
endmodule

// File: tb/tb_sigmoid_backprop.sv
// Directed self-checking bench for sigmoid_backprop (default 32-bit format).
module tb_sigmoid_backprop;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [2:0]  round_mode = 3'd0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_s = '0;
    logic [31:0] in_grad = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_delta;
`ifdef SIGMOID_BACKPROP_EXC_EN
    logic [4:0]  exc_flags;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] vs [8];
    logic [31:0] vg [8];
    logic [31:0] ve [8];

    sigmoid_backprop dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .round_mode (round_mode),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_grad    (in_grad),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SIGMOID_BACKPROP_EXC_EN
        .exc_flags  (exc_flags),
`endif
        .out_delta  (out_delta)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns one falling edge after the accepting edge.
    task automatic drive_accept(input logic [31:0] s, input logic [31:0] g);
        in_s     = s;
        in_grad  = g;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_s     = 32'hdeadbeef;
        in_grad  = 32'h7f7fffff;
    endtask

    // lat = rising edges after the accepting edge; 20 means timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_delta !== 32'h0) begin errors++; $display("FAIL reset_out_delta got %h expected 0", out_delta); end
`ifdef SIGMOID_BACKPROP_EXC_EN
        checks++; if (exc_flags !== 5'h0) begin errors++; $display("FAIL reset_exc got %h expected 0", exc_flags); end
`endif
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        int lat;
        vs = '{32'h3f000000, 32'h3f400000, 32'h3f000000, 32'h3f800000,
               32'h3f800000, 32'h00000000, 32'h3e800000, 32'h40000000};
        vg = '{32'h3f800000, 32'h40000000, 32'hc0800000, 32'h40a00000,
               32'hc0a00000, 32'h40400000, 32'h3f800000, 32'h3f800000};
        ve = '{32'h3e800000, 32'h3ec00000, 32'hbf800000, 32'h00000000,
               32'h80000000, 32'h00000000, 32'h3e400000, 32'hc0000000};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_ready_before got %b expected 1", i, in_ready); end
            drive_accept(vs[i], vg[i]);
            wait_valid(lat);
            checks++; if (lat != 3) begin errors++; $display("FAIL vec%0d_latency got %0d expected 3", i, lat); end
            checks++; if (out_delta !== ve[i]) begin errors++; $display("FAIL vec%0d_delta got %h expected %h", i, out_delta, ve[i]); end
`ifdef SIGMOID_BACKPROP_EXC_EN
            checks++; if (exc_flags !== 5'h0) begin errors++; $display("FAIL vec%0d_exc got %h expected 0", i, exc_flags); end
`endif
            @(negedge clk);
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL vec%0d_after_handshake got ready=%b valid=%b expected 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        drive_accept(32'h3f000000, 32'h3f800000);
        wait_valid(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL bp_latency got %0d expected 3", lat); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got %b expected 1", i, out_valid); end
            checks++; if (out_delta !== 32'h3e800000) begin errors++; $display("FAIL bp_delta_%0d got %h expected 3e800000", i, out_delta); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d got %b expected 0", i, in_ready); end
            in_valid = i[0];
            in_s     = 32'h3f400000;
            in_grad  = 32'h40000000;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got ready=%b valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int   lat;
        logic seen;
        drive_accept(32'h3f400000, 32'h40000000);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle got ready=%b valid=%b expected 1/0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid got %b expected 0", seen); end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_s     = 32'h3f000000;
        in_grad  = 32'h3f800000;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_priority_ready got %b expected 1", in_ready); end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_priority_valid got %b expected 0", seen); end
        drive_accept(32'h3f000000, 32'hc0800000);
        wait_valid(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL flush_next_latency got %0d expected 3", lat); end
        checks++; if (out_delta !== 32'hbf800000) begin errors++; $display("FAIL flush_next_delta got %h expected bf800000", out_delta); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int   lat;
        logic seen;
        drive_accept(32'h3f400000, 32'h40000000);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b expected 0", out_valid); end
        checks++; if (out_delta !== 32'h0) begin errors++; $display("FAIL arst_delta got %h expected 0", out_delta); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b expected 1", in_ready); end
        @(negedge clk);
        rst_l = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL arst_no_partial got %b expected 0", seen); end
        drive_accept(32'h3f000000, 32'h3f800000);
        wait_valid(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL arst_next_latency got %0d expected 3", lat); end
        checks++; if (out_delta !== 32'h3e800000) begin errors++; $display("FAIL arst_next_delta got %h expected 3e800000", out_delta); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
